pf_lanectrl_pause_seq: RTL and testbench
========================================

// Module: pf_lanectrl_pause_seq
// PURPOSE
//  Lane-control pause sequencer, directly upstream of the lane pause synchroniser.
//  Takes delay-move requests from training/calibration logic and brackets each move with HS_IO_CLK_PAUSE.
//  Sequence per request: assert pause, wait guard cycles, emit delay-line step strobes, wait guard cycles, release pause.
//  A minimum gap is enforced between pauses so the downstream sync/extension stage always sees clean, separated pulses.
// PARAMETERS
//  PRE_CYCLES   2  pause-high cycles before the first step strobe; legal range 1..15
//  POST_CYCLES  3  pause-high cycles after the last step strobe; legal range 1..15
//  MIN_GAP      4  cycles from ACK (inclusive) before a new request is sampled; legal range 1..15
//  STEP_W       6  width of the step-count request field
// PORTS
//  CLK              in   1       lane control clock
//  RESET            in   1       asynchronous active-high reset
//  REQ              in   1       move request, level; held by requester until ACK
//  REQ_STEPS        in   STEP_W  delay steps to move; 0 = pause-only cycle
//  REQ_DIR          in   1       move direction: 1 = increment, 0 = decrement
//  ACK              out  1       one-cycle completion pulse
//  BUSY             out  1       high from the cycle after REQ is accepted until the return to IDLE
//  HS_IO_CLK_PAUSE  out  1       pause request to the pause synchroniser
//  DLY_MOVE         out  1       one-cycle delay-line step strobe
//  DLY_DIR          out  1       delay-line direction, stable for the whole pause window
// BEHAVIOUR
//  - Clock and reset: one clock, CLK; reset is asynchronous and active-high on RESET.
//  - Reset values: all outputs 0; FSM in IDLE; latched steps and dir cleared.
//  - All outputs are driven directly from flops, with no combinational path from inputs; HS_IO_CLK_PAUSE must be glitch-free.
//  - FSM states: IDLE, PRE, MOVE, POST, GAP.
//  - IDLE:
//    - BUSY=0.
//    - REQ=1 sampled at edge N: latch REQ_STEPS and REQ_DIR; go to PRE.
//    - From cycle N+1: HS_IO_CLK_PAUSE=1, BUSY=1, DLY_DIR=latched dir.
//  - PRE:
//    - Lasts exactly PRE_CYCLES cycles.
//    - Then go to MOVE if latched steps != 0, else go to POST.
//  - MOVE:
//    - 2 cycles per step: DLY_MOVE=1 in the first cycle, 0 in the second.
//    - Lasts exactly 2*steps cycles.
//    - A down-counter with STEP_W bits is loaded with steps; it must not wrap (steps=2^STEP_W-1 is legal).
//  - POST:
//    - Lasts exactly POST_CYCLES cycles.
//    - On exit: HS_IO_CLK_PAUSE=0 and ACK=1 in the same cycle (the first GAP cycle).
//  - Pause high width = PRE_CYCLES + 2*steps + POST_CYCLES cycles (minimum 2).
//  - GAP:
//    - Lasts MIN_GAP cycles, counting the ACK cycle.
//    - BUSY=1; REQ ignored; then go to IDLE.
//  - REQ is only sampled in IDLE. REQ_STEPS/REQ_DIR changes while BUSY are ignored.
//  - If REQ stays high after ACK, a new operation starts. Pause is then low for exactly MIN_GAP+1 cycles between operations.
//  - DLY_DIR holds its value after the pause until the next accept. DLY_MOVE is never 1 while HS_IO_CLK_PAUSE=0.
//  - Reset mid-operation: all outputs drop to 0 asynchronously; no ACK is issued; FSM returns to IDLE.
//    The requester must re-issue REQ after reset release.
//  - Out-of-range parameters are a static error (elaboration check); no runtime clamping.
// TESTING
//  1. Assert RESET with REQ=1 -> all outputs 0 during reset; BUSY rises 1 cycle after reset release.
//  2. Defaults, REQ_STEPS=0 -> pause high 5 cycles; no DLY_MOVE; ACK in first pause-low cycle; BUSY falls 4 cycles after ACK.
//  3. REQ_STEPS=3, REQ_DIR=1 -> DLY_MOVE high at pause cycles 3, 5, 7 (1-based); pause high 11 cycles; DLY_DIR=1 throughout.
//  4. REQ held high across 2 operations (STEPS=1) -> each pause high 7 cycles; pause low exactly 5 cycles in between.
//  5. RESET pulsed in the 2nd MOVE cycle (STEPS=4) -> pause/DLY_MOVE drop same cycle, no ACK; next REQ STEPS=1 -> normal 7-cycle pause.
//  6. REQ_STEPS=63 -> exactly 63 DLY_MOVE pulses; pause high 131 cycles; no counter wrap; single ACK.

Source files
------------

// File: rtl/pf_lanectrl_pause_seq.sv
`default_nettype none
// ============================================================================
// Module      : pf_lanectrl_pause_seq
// Description : Brackets each delay-line move with HS_IO_CLK_PAUSE, using
//               guard cycles before and after the move and a minimum gap
//               between pauses.
// Revision    : 1.0 - initial release
// ============================================================================
module pf_lanectrl_pause_seq #(
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 3,
    parameter int MIN_GAP     = 4,
    parameter int STEP_W      = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic [STEP_W-1:0] REQ_STEPS,
    input  logic              REQ_DIR,
    output logic              ACK,
    output logic              BUSY,
    output logic              HS_IO_CLK_PAUSE,
    output logic              DLY_MOVE,
    output logic              DLY_DIR
);

    if (PRE_CYCLES < 1 || PRE_CYCLES > 15) begin : g_bad_pre
        $error("PRE_CYCLES must be in 1..15");
    end
    if (POST_CYCLES < 1 || POST_CYCLES > 15) begin : g_bad_post
        $error("POST_CYCLES must be in 1..15");
    end
    if (MIN_GAP < 1 || MIN_GAP > 15) begin : g_bad_gap
        $error("MIN_GAP must be in 1..15");
    end
    if (STEP_W < 1) begin : g_bad_step_w
        $error("STEP_W must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_MOVE = 3'd2,
        S_POST = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    // Counter reload values are "length - 1" so each phase ends on r_cnt == 0.
    localparam logic [3:0] c_pre_load  = 4'(PRE_CYCLES - 1);
    localparam logic [3:0] c_post_load = 4'(POST_CYCLES - 1);
    localparam logic [3:0] c_gap_load  = 4'(MIN_GAP - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [STEP_W-1:0] r_steps;
    logic              r_half;
    logic              r_ack;
    logic              r_busy;
    logic              r_pause;
    logic              r_move;
    logic              r_dir;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_steps <= '0;
            r_half  <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_pause <= 1'b0;
            r_move  <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_state <= S_PRE;
                        r_cnt   <= c_pre_load;
                        r_steps <= REQ_STEPS;
                        r_dir   <= REQ_DIR;
                        r_pause <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (r_cnt == 4'd0) begin
                        if (r_steps != '0) begin
                            r_state <= S_MOVE;
                            r_move  <= 1'b1;
                            r_half  <= 1'b0;
                        end else begin
                            r_state <= S_POST;
                            r_cnt   <= c_post_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_MOVE: begin
                    // Strobe half, then quiet half; the step count stops at 1
                    // so a full-scale request never wraps.
                    if (!r_half) begin
                        r_move <= 1'b0;
                        r_half <= 1'b1;
                    end else if (r_steps == STEP_W'(1)) begin
                        r_state <= S_POST;
                        r_cnt   <= c_post_load;
                        r_half  <= 1'b0;
                    end else begin
                        r_steps <= r_steps - STEP_W'(1);
                        r_move  <= 1'b1;
                        r_half  <= 1'b0;
                    end
                end
                S_POST: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_GAP;
                        r_cnt   <= c_gap_load;
                        r_pause <= 1'b0;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pause <= 1'b0;
                    r_move  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ACK             = r_ack;
    assign BUSY            = r_busy;
    assign HS_IO_CLK_PAUSE = r_pause;
    assign DLY_MOVE        = r_move;
    assign DLY_DIR         = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_pf_lanectrl_pause_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pf_lanectrl_pause_seq
// Description : Randomised scoreboard bench for pf_lanectrl_pause_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pf_lanectrl_pause_seq;

    localparam int PRE  = 2;
    localparam int POST = 3;
    localparam int GAP  = 4;
    localparam int SW   = 6;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          REQ;
    logic [SW-1:0] REQ_STEPS;
    logic          REQ_DIR;
    logic          ACK;
    logic          BUSY;
    logic          HS_IO_CLK_PAUSE;
    logic          DLY_MOVE;
    logic          DLY_DIR;

    pf_lanectrl_pause_seq #(
        .PRE_CYCLES (PRE),
        .POST_CYCLES(POST),
        .MIN_GAP    (GAP),
        .STEP_W     (SW)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .REQ            (REQ),
        .REQ_STEPS      (REQ_STEPS),
        .REQ_DIR        (REQ_DIR),
        .ACK            (ACK),
        .BUSY           (BUSY),
        .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE),
        .DLY_MOVE       (DLY_MOVE),
        .DLY_DIR        (DLY_DIR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int steps;
        bit dir;
        bit b2b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   aborted = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: measures each pause window and compares it with the
    // scoreboard entry of the request that caused it.
    // ------------------------------------------------------------------
    bit   in_pause = 0, have_prev = 0, post_ack = 0, wdir = 0, last_dir = 0;
    int   width, moves, pos_bad, dir_bad, busy_bad, cur_steps, low_cnt, bcnt;
    exp_t e;

    always @(negedge CLK) begin
        if (RESET) begin
            in_pause  = 0;
            have_prev = 0;
            post_ack  = 0;
        end else begin
            if (DLY_MOVE && !HS_IO_CLK_PAUSE) check("move_outside_pause", 1, 0);
            if (HS_IO_CLK_PAUSE) begin
                if (!in_pause) begin
                    in_pause  = 1;
                    width     = 0;
                    moves     = 0;
                    pos_bad   = 0;
                    dir_bad   = 0;
                    busy_bad  = 0;
                    wdir      = DLY_DIR;
                    cur_steps = (sb.size() > 0) ? sb[0].steps : 0;
                    if (have_prev && sb.size() > 0) begin
                        if (sb[0].b2b) check("gap_b2b_len", low_cnt, GAP + 1);
                        else           check("gap_min_ok", int'(low_cnt >= GAP + 1), 1);
                    end
                end
                width++;
                if (DLY_MOVE) moves++;
                if (DLY_MOVE != ((width > PRE) && (width <= PRE + 2 * cur_steps)
                                 && (((width - PRE) % 2) == 1))) pos_bad++;
                if (DLY_DIR != wdir) dir_bad++;
                if (!BUSY) busy_bad++;
                check("ack_in_pause", int'(ACK), 0);
            end else if (in_pause) begin
                in_pause  = 0;
                have_prev = 1;
                last_dir  = wdir;
                low_cnt   = 1;
                check("ack_at_release", int'(ACK), 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_op: pause window of %0d cycles with empty scoreboard", width);
                end else begin
                    e = sb.pop_front();
                    check("pause_width", width, PRE + 2 * e.steps + POST);
                    check("move_count", moves, e.steps);
                    check("move_positions_bad", pos_bad, 0);
                    check("dir_value", int'(wdir), int'(e.dir));
                    check("dir_unstable", dir_bad, 0);
                    check("busy_low_in_pause", busy_bad, 0);
                end
                post_ack = 1;
                bcnt     = BUSY ? 1 : 0;
            end else begin
                low_cnt++;
                check("ack_spurious", int'(ACK), 0);
                if (have_prev) check("dir_hold", int'(DLY_DIR), int'(last_dir));
                if (post_ack) begin
                    if (BUSY) bcnt++;
                    else begin
                        check("busy_after_ack", bcnt, GAP);
                        post_ack = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic wait_ack();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (ACK) begin
                ok = 1;
                break;
            end
            // Request fields are don't-care once the move is under way.
            if (HS_IO_CLK_PAUSE) begin
                REQ_STEPS = SW'($urandom);
                REQ_DIR   = 1'($urandom_range(0, 1));
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ACK within 400 cycles, expected one");
            aborted = 1;
        end
    endtask

    task automatic issue(input int steps, input bit dir, input bit b2b);
        if (aborted) return;
        if (!b2b) begin
            REQ = 1'b0;
            repeat (1 + $urandom_range(0, 4)) @(negedge CLK);
        end
        REQ_STEPS = SW'(steps);
        REQ_DIR   = dir;
        REQ       = 1'b1;
        sb.push_back(exp_t'{steps: steps, dir: dir, b2b: b2b});
        wait_ack();
    endtask

    task automatic reset_mid_move();
        bit seen = 0;
        if (aborted) return;
        REQ = 1'b0;
        repeat (2) @(negedge CLK);
        REQ_STEPS = SW'(4);
        REQ_DIR   = 1'b1;
        REQ       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (HS_IO_CLK_PAUSE) begin
                seen = 1;
                break;
            end
        end
        check("mid_reset_pause_seen", int'(seen), 1);
        repeat (PRE + 1) @(negedge CLK);
        check("mid_reset_pause_before", int'(HS_IO_CLK_PAUSE), 1);
        #2 RESET = 1'b1;
        #1;
        check("mid_reset_outputs", int'({ACK, BUSY, HS_IO_CLK_PAUSE, DLY_MOVE, DLY_DIR}), 0);
        REQ = 1'b0;
        repeat (2) @(negedge CLK);
        check("mid_reset_hold_outputs", int'({ACK, BUSY, HS_IO_CLK_PAUSE, DLY_MOVE, DLY_DIR}), 0);
        #2 RESET = 1'b0;
    endtask

    initial begin
        int s;
        RESET     = 1'b0;
        REQ       = 1'b1;
        REQ_STEPS = '0;
        REQ_DIR   = 1'b0;
        #1 RESET  = 1'b1;

        // Reset held while REQ is already high.
        repeat (3) @(negedge CLK);
        check("reset_outputs", int'({ACK, BUSY, HS_IO_CLK_PAUSE, DLY_MOVE, DLY_DIR}), 0);
        sb.push_back(exp_t'{steps: 0, dir: 1'b0, b2b: 1'b0});
        #2 RESET = 1'b0;
        @(negedge CLK);
        check("busy_after_release", int'(BUSY), 1);
        check("pause_after_release", int'(HS_IO_CLK_PAUSE), 1);
        wait_ack();

        issue(3, 1'b1, 1'b0);
        issue(1, 1'b0, 1'b0);
        issue(1, 1'b1, 1'b1);
        reset_mid_move();
        issue(1, 1'b0, 1'b0);
        issue(63, 1'b1, 1'b0);
        issue(62, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       s = 63;
                1:       s = 0;
                default: s = $urandom_range(1, 8);
            endcase
            issue(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        REQ = 1'b0;
        repeat (GAP + 4) @(negedge CLK);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
